// File: rtl/bin_to_bcd_seq_pkg.sv
// bcd_pkg: shared types, constants and the overflow limit helper for bin_to_bcd_seq
//   conv_state_t    : converter FSM states
//   bcd_digit_t     : one packed BCD digit
//   BCD_NINE        : digit value used to fill a saturated result
//   max_bcd_value() : largest value representable in a given number of BCD digits
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
   typedef logic [3:0] bcd_digit_t;
   localparam bcd_digit_t BCD_NINE = 4'h9;
   function automatic int unsigned max_bcd_value(input int unsigned digits);
      int unsigned v;
      v = 1;
      for (int unsigned i = 0; i < digits; i++) v = v * 10;
      return v - 1;
   endfunction
endpackage

// File: rtl/bcd_add3_digit.sv
// bcd_add3_digit: double-dabble nibble corrector, adds 3 when the digit is 5 or more
//   i_digit : scratch nibble before the shift
//   o_digit : corrected nibble (no carry out)
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  bcd_digit_t i_digit,
   output bcd_digit_t o_digit
);
   assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed BCD converter, saturating to all nines
//   clk_in   : clock, rising edge
//   reset    : asynchronous active-high reset
//   start    : conversion request, sampled only while idle
//   bin_in   : binary value captured on the accepting edge
//   busy     : conversion in progress (registered)
//   done     : one-cycle pulse when bcd_out/overflow have just been updated
//   overflow : last captured value exceeded 10^DIGITS-1
//   bcd_out  : packed BCD result, most significant digit in the top nibble
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
)(
   input  logic                clk_in,
   input  logic                reset,
   input  logic                start,
   input  logic [WIDTH-1:0]    bin_in,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [4*DIGITS-1:0] bcd_out
);
   localparam int SW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [31:0]   MAX_VAL = 32'(max_bcd_value(DIGITS));
   localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

   conv_state_t     r_state, w_next;
   logic            w_accept, w_iter;
   logic [WIDTH-1:0] r_bin;
   logic [SW-1:0]   r_scr, w_adj, r_bcd;
   logic [CW-1:0]   r_cnt;
   logic            r_flag, r_busy, r_done, r_ovf;

   for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      bcd_add3_digit u_add (
         .i_digit(r_scr[4*d +: 4]),
         .o_digit(w_adj[4*d +: 4])
      );
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_iter   = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_accept = start;
            w_next   = start ? SHIFT : IDLE;
         end
         SHIFT: begin
            w_iter = 1'b1;
            // the iteration happening on this edge is the last one
            w_next = (r_cnt == LAST) ? DONE : SHIFT;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_bin  <= '0;
         r_scr  <= '0;
         r_cnt  <= '0;
         r_flag <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_ovf  <= 1'b0;
         r_bcd  <= '0;
      end else begin
         r_busy <= (w_next != IDLE);
         r_done <= (r_state == DONE);
         if (w_accept) begin
            r_bin  <= bin_in;
            r_scr  <= '0;
            r_cnt  <= '0;
            r_flag <= {{(32-WIDTH){1'b0}}, bin_in} > MAX_VAL;
         end
         if (w_iter) begin
            // correct first, then shift {scratch, binary} left by one
            r_scr <= {w_adj[SW-2:0], r_bin[WIDTH-1]};
            r_bin <= {r_bin[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
         end
         if (r_state == DONE) begin
            r_bcd <= r_flag ? {DIGITS{BCD_NINE}} : r_scr;
            r_ovf <= r_flag;
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign overflow = r_ovf;
   assign bcd_out  = r_bcd;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq with directed vectors
module tb_bin_to_bcd_seq;
   logic        clk_in = 1'b0;
   logic        reset  = 1'b1;
   logic        start  = 1'b0;
   logic [13:0] bin_in = '0;
   logic        busy, done, overflow;
   logic [15:0] bcd_out;
   logic [16:0] sb[$];
   int          n_chk = 0, n_pass = 0, n_done = 0;

   bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
      .clk_in(clk_in), .reset(reset), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .overflow(overflow), .bcd_out(bcd_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk_in) begin
      if (done === 1'b1) begin
         n_done++;
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: got bcd %0h expected no done at %0t", bcd_out, $time);
         end else begin
            logic [16:0] e;
            e = sb.pop_front();
            chk("bcd_out", {16'h0, bcd_out}, {16'h0, e[15:0]});
            chk("overflow", {31'h0, overflow}, {31'h0, e[16]});
         end
      end
   end

   // called just after a negedge; k-th following negedge samples after edge k-1
   task automatic run(input logic [13:0] v, input logic [15:0] eb, input logic eo, input int pulse_k);
      start  = 1'b1;
      bin_in = v;
      sb.push_back({eo, eb});
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk_in);
         if (k == 1) start = 1'b0;
         if (k == pulse_k) begin start = 1'b1; bin_in = 14'd1111; end
         if (k == pulse_k + 1) start = 1'b0;
         chk($sformatf("busy_k%0d", k), {31'h0, busy}, {31'h0, k <= 15});
         chk($sformatf("done_k%0d", k), {31'h0, done}, {31'h0, k == 16});
      end
      #1;
      chk("result_arrived", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int d0;
      repeat (2) @(negedge clk_in);
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_done", {31'h0, done}, 0);
      chk("rst_ovf", {31'h0, overflow}, 0);
      chk("rst_bcd", {16'h0, bcd_out}, 0);
      reset = 1'b0;
      run(14'd0,     16'h0000, 1'b0, -5);
      run(14'd1234,  16'h1234, 1'b0, -5);
      run(14'd9999,  16'h9999, 1'b0, -5);
      run(14'd12000, 16'h9999, 1'b1, -5);
      run(14'd42,    16'h0042, 1'b0, -5);
      run(14'd10000, 16'h9999, 1'b1, -5);
      run(14'd16383, 16'h9999, 1'b1, -5);
      run(14'd7,     16'h0007, 1'b0, -5);
      d0 = n_done;
      run(14'd5678,  16'h5678, 1'b0, 5);
      repeat (20) @(negedge clk_in);
      chk("single_done", n_done - d0, 1);
      chk("ignored_hold", {16'h0, bcd_out}, 32'h5678);
      // abort a conversion with reset between edges 7 and 8
      d0 = n_done;
      start  = 1'b1;
      bin_in = 14'd4321;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_in);
         if (k == 1) start = 1'b0;
      end
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", {31'h0, busy}, 0);
      chk("abort_done", {31'h0, done}, 0);
      chk("abort_ovf", {31'h0, overflow}, 0);
      chk("abort_bcd", {16'h0, bcd_out}, 0);
      @(negedge clk_in);
      reset = 1'b0;
      repeat (20) @(negedge clk_in);
      chk("abort_no_done", n_done - d0, 0);
      run(14'd800, 16'h0800, 1'b0, -5);
      // start held high, bin_in stepping one value per clock
      d0 = n_done;
      for (int c = 0; c <= 66; c++) begin
         start  = (c <= 48);
         bin_in = (c <= 50) ? 14'(c) : 14'd0;
         if (c == 0)  sb.push_back({1'b0, 16'h0000});
         if (c == 16) sb.push_back({1'b0, 16'h0016});
         if (c == 32) sb.push_back({1'b0, 16'h0032});
         if (c == 48) sb.push_back({1'b0, 16'h0048});
         @(negedge clk_in);
      end
      #1;
      chk("held_all_done", sb.size(), 0);
      chk("held_done_count", n_done - d0, 4);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential double-dabble converter that turns a binary count into packed BCD digits for the multiplexed seven-segment display path. It sits directly upstream of the digit multiplexer and BCD-to-seven-segment decoder. It lets a plain binary counter or accumulator drive the 4-digit display. It uses a start/busy/done handshake, one shift-and-correct iteration per clock, and saturates to all nines when the input exceeds the displayable range.

## Interface
- `WIDTH`, default 14: binary input width. Must satisfy 4 ≤ WIDTH ≤ 20.
- `DIGITS`, default 4: number of BCD digits produced.
- `clk_in`, input, 1: single clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request conversion of `bin_in`. Sampled only in IDLE.
- `bin_in`, input, WIDTH: binary value. Captured on the accepting edge only.
- `busy`, output, 1: conversion in progress.
- `done`, output, 1: one-cycle pulse. Result registers have just been updated.
- `overflow`, output, 1: last captured value exceeded 10^DIGITS−1. Valid with and after `done`.
- `bcd_out`, output, 4·DIGITS: packed BCD result, most significant digit in the top nibble. Held between conversions.

## Operation
- FSM states:
  - IDLE → SHIFT when `start`=1.
  - SHIFT → DONE after exactly WIDTH iterations.
  - DONE → IDLE unconditionally.
- Accept (IDLE, `start`=1):
  - Load the binary shift register with `bin_in`.
  - Clear the BCD scratch register (4·DIGITS bits) and the iteration counter.
  - Latch the overflow compare `bin_in > 10^DIGITS−1` into an internal flag.
- SHIFT iteration, one per clock:
  - Every scratch nibble ≥ 5 gets +3 (nibble arithmetic, no carry between nibbles).
  - Then shift {scratch, binary} left by 1; the binary MSB enters the scratch LSB.
  - Counter increments. Counter width is ceil(log2(WIDTH+1)); it never wraps within a conversion.
- DONE:
  - `bcd_out` ← scratch if the flag is 0, else all nibbles 4'h9.
  - `overflow` ← flag.
  - `done` ← 1 for this one cycle.
- `start` outside IDLE is ignored. There is no queueing, and `bin_in` changes during SHIFT have no effect.
- `start` held high continuously gives back-to-back conversions, each re-capturing `bin_in`.
- `bin_in` = 0 converts normally to all-zero digits, with full latency.

## Timing
- Edge numbering: edge 0 is the rising edge at which `start`=1 is sampled in IDLE.
- `busy`:
  - Registered.
  - 1 from edge 0 until edge WIDTH+1.
  - 0 otherwise, including in IDLE.
- Iterations occur at edges 1 through WIDTH. State is DONE after edge WIDTH.
- At edge WIDTH+1:
  - `bcd_out` and `overflow` update.
  - `done` goes to 1.
  - `busy` goes to 0.
  - State returns to IDLE.
- `done` returns to 0 at edge WIDTH+2.
- A new `start` can be accepted at edge WIDTH+2, while `done` is high.
- Latency from accept to `done` is WIDTH+1 clocks; with defaults, `done` is high after edge 15. Minimum start-to-start spacing is WIDTH+2 clocks.
- Reset (asynchronous, any state, including mid-SHIFT):
  - State → IDLE.
  - `busy`=0, `done`=0, `overflow`=0, `bcd_out`=0.
  - Scratch registers and counter cleared.
  - An interrupted conversion is discarded and produces no `done`.
- First accept is possible at the first rising edge after `reset` deasserts.

## Structure
- Package `bcd_pkg` holds:
  - FSM state enum `conv_state_t` {IDLE, SHIFT, DONE}.
  - Digit type `bcd_digit_t` (logic [3:0]).
  - Constant `BCD_NINE` = 4'h9.
  - Function `max_bcd_value(DIGITS)` returning 10^DIGITS−1, used for the overflow compare.
- One sub-module: `bcd_add3_digit`, a combinational nibble corrector that outputs the input +3 when the input is ≥ 5 and passes it through otherwise. It is instantiated DIGITS times via generate.
- All outputs are driven directly from registers. There is no combinational path from `start` or `bin_in` to any output.

## Test plan
- Reset, then `start` with `bin_in`=0 → `done` high after edge 15 with `bcd_out`=16'h0000 and `overflow`=0; `busy` high for edges 0–14.
- `bin_in`=1234 → `bcd_out`=16'h1234; then `bin_in`=9999 → 16'h9999 with `overflow`=0.
- `bin_in`=12000 → `bcd_out`=16'h9999 with `overflow`=1; a following 42 → 16'h0042 with `overflow`=0.
- Start 5678, then pulse `start` with `bin_in`=1111 at edge 5 → ignored; the result is 16'h5678 and exactly one `done`.
- Start 4321, assert `reset` between edges 7 and 8 → all outputs zero immediately and no `done`; restart with 800 → 16'h0800.
- `start` held high with `bin_in` stepping 0…50 → `done` pulses every 16 clocks and each result matches the value captured at its accepting edge.
